// File: rtl/mul_div_unit_if.sv
// Issue / write-back bundle between the control FSM, register file and mul_div_unit.
interface mul_div_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      funct3;
    logic [4:0]      rd_in;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            reg_write;

    modport master (output start, funct3, rd_in, operand_a, operand_b,
                    input  busy, done, result, rd_out, reg_write);
    modport slave  (input  start, funct3, rd_in, operand_a, operand_b,
                    output busy, done, result, rd_out, reg_write);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide on magnitudes.
// state | meaning
// IDLE  | waiting for start, operands latched on acceptance
// CALC  | count 0 loads magnitudes, counts 1..XLEN run one step each
// FIX   | sign correction, special-case selection, result/rd latched
// DONE  | one-cycle done / write-back pulse
module mul_div_unit #(parameter int XLEN = 32) (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     count;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [2*XLEN-1:0] acc;      // mul: {partial high, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   mdr;      // multiplicand or divisor magnitude
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;
    logic              busy, done;

    logic              is_div, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;

    assign is_div   = op_q[2];
    assign a_signed = (op_q != 3'b011) && (op_q != 3'b101) && (op_q != 3'b111);
    assign b_signed = a_signed && (op_q != 3'b010);
    assign a_neg    = a_signed && a_q[XLEN-1];
    assign b_neg    = b_signed && b_q[XLEN-1];
    assign mag_a    = a_neg ? -a_q : a_q;
    assign mag_b    = b_neg ? -b_q : b_q;

    logic [XLEN:0] mul_sum, div_shift, div_diff;
    logic          div_ge;

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mdr} : '0);
    assign div_shift = acc[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, mdr};
    assign div_ge    = !div_diff[XLEN];

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    assign prod_s = (a_neg ^ b_neg) ? -acc : acc;
    assign quo_s  = (a_neg ^ b_neg) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_s  = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    // Signed overflow (min / -1) falls out of the magnitude path without a special case.
    always_comb begin
        fix_res = '0;
        case (op_q)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = (b_q == '0) ? '1 : quo_s;
            default:                fix_res = (b_q == '0) ? a_q : rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) state_nxt = CALC;
            end
            CALC: if (count == CW'(XLEN)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            mdr      <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    op_q  <= bus.funct3;
                    rd_q  <= bus.rd_in;
                    a_q   <= bus.operand_a;
                    b_q   <= bus.operand_b;
                    count <= '0;
                end
                CALC: begin
                    count <= count + CW'(1);
                    if (count == '0) begin
                        acc <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                        mdr <= is_div ? mag_b : mag_a;
                    end else if (is_div) begin
                        acc <= {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                                acc[XLEN-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                    end
                end
                FIX: begin
                    result_q <= fix_res;
                    rd_out_q <= rd_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.result    = result_q;
    assign bus.rd_out    = rd_out_q;
    assign bus.reg_write = done && (rd_out_q != 5'd0);
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: constant vector table, model-driven random ops, corner sequences.
module tb_mul_div_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_div_unit_if #(.XLEN(XLEN)) bus ();
    mul_div_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [2:0]  f;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb64, ubs;
        logic        [63:0] ua, ub, p;
        logic signed [31:0] s32a, s32b, sq;
        sa   = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ua   = {32'b0, a};
        ub   = {32'b0, b};
        ubs  = ub;
        s32a = a;
        s32b = b;
        p    = '0;
        sq   = '0;
        case (f)
            3'b000: begin p = sa * sb64; return p[31:0]; end
            3'b001: begin p = sa * sb64; return p[63:32]; end
            3'b010: begin p = sa * ubs;  return p[63:32]; end
            3'b011: begin p = ua * ub;   return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                sq = s32a / s32b;
                return sq;
            end
            3'b101: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                sq = s32a % s32b;
                return sq;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input bit poke);
        exp_t e;
        int   cnt;
        int   extra;
        bit   seen;
        e.res = res;
        e.rd  = rd;
        e.rw  = (rd != 5'd0);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f; bus.rd_in = rd;
        bus.operand_a = a; bus.operand_b = b;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.operand_a = ~a; bus.operand_b = $urandom;
        bus.funct3 = ~f; bus.rd_in = ~rd;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 60) begin
            if (poke && cnt == 10) bus.start = 1'b1;
            if (poke && cnt == 11) bus.start = 1'b0;
            @(posedge clk); #1;
            cnt++;
            seen = bus.done;
        end
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles, expected 34", cnt);
            sb.delete();
            return;
        end
        check("latency", 32'(cnt), 32'd34);
        if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard: done with no expected entry, got result %h", bus.result);
            return;
        end
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("rd_out", 32'(bus.rd_out), 32'(e.rd));
        check("reg_write", 32'(bus.reg_write), 32'(e.rw));
        check("busy_in_done", 32'(bus.busy), 32'd1);
        if (poke) bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("reg_write_clear", 32'(bus.reg_write), 32'd0);
        check("busy_clear", 32'(bus.busy), 32'd0);
        check("result_held", bus.result, e.res);
        if (poke) begin
            extra = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (bus.done) extra++;
            end
            check("ignored_start_no_done", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        int          pulses;

        vecs[0]  = '{3'b000, 5'd5,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{3'b001, 5'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[2]  = '{3'b010, 5'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[3]  = '{3'b011, 5'd3,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[4]  = '{3'b100, 5'd4,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
        vecs[5]  = '{3'b110, 5'd6,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
        vecs[6]  = '{3'b101, 5'd7,  32'd100,      32'd7,        32'd14};
        vecs[7]  = '{3'b111, 5'd8,  32'd100,      32'd7,        32'd2};
        vecs[8]  = '{3'b100, 5'd9,  32'h12345678, 32'h00000000, 32'hFFFFFFFF};
        vecs[9]  = '{3'b111, 5'd10, 32'h12345678, 32'h00000000, 32'h12345678};
        vecs[10] = '{3'b100, 5'd11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{3'b110, 5'd12, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[12] = '{3'b000, 5'd0,  32'd3,        32'd4,        32'd12};

        reset = 1'b1;
        bus.start = 1'b0; bus.funct3 = '0; bus.rd_in = '0;
        bus.operand_a = '0; bus.operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_rd_out", 32'(bus.rd_out), 32'd0);
        check("reset_reg_write", 32'(bus.reg_write), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++)
            run_op(vecs[i].f, vecs[i].rd, vecs[i].a, vecs[i].b, vecs[i].res, 1'b0);

        for (int i = 0; i < 10; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op(rf, 5'($urandom_range(1, 31)), ra, rb, model(rf, ra, rb), 1'b0);
        end

        // Starts during CALC and DONE must be dropped.
        run_op(3'b000, 5'd13, 32'd3, 32'd4, 32'd12, 1'b1);

        // Reset in the middle of a divide discards it entirely.
        run_op(3'b000, 5'd20, 32'd9, 32'd9, 32'd81, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.rd_in = 5'd21;
        bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_result", bus.result, 32'd0);
        check("midreset_rd_out", 32'(bus.rd_out), 32'd0);
        check("midreset_reg_write", 32'(bus.reg_write), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        check("midreset_no_done", 32'(pulses), 32'd0);
        run_op(3'b000, 5'd22, 32'd1234, 32'd5678, 32'd7006652, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
